// File: rtl/minmax_scan_ctrl.sv
module comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       c,
  output logic       d,
  output logic       e
);

  assign c = (a > b);
  assign d = (a == b);
  assign e = (a < b);

endmodule

module minmax_scan_ctrl #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [3:0]      in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_max,
  output logic [3:0]      out_min,
  output logic [IDXW-1:0] out_max_idx,
  output logic [IDXW-1:0] out_min_idx
);

  typedef enum logic [2:0] {
    FIRST   = 3'd0,
    NEXT    = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [IDXW:0] CNT_LAST = (IDXW + 1)'(N - 1);

  state_t          state;
  state_t          state_nx;
  logic [3:0]      sample_q;
  logic [3:0]      max_q;
  logic [3:0]      min_q;
  logic [IDXW-1:0] max_idx_q;
  logic [IDXW-1:0] min_idx_q;
  logic [IDXW:0]   cnt_q;

  logic [3:0]      cmp_b;
  logic            cmp_gt;
  logic            cmp_eq_unused;
  logic            cmp_lt;

  // One shared comparator: A is the held sample, B selects the running extreme.
  assign cmp_b = (state == CMP_MIN) ? min_q : max_q;

  comparator u_cmp (
    .a (sample_q),
    .b (cmp_b),
    .c (cmp_gt),
    .d (cmp_eq_unused),
    .e (cmp_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = NEXT;
      end
      NEXT: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CMP_MAX;
      end
      CMP_MAX: state_nx = CMP_MIN;
      CMP_MIN: state_nx = (cnt_q == CNT_LAST) ? DONE : NEXT;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = FIRST;
      end
      default: state_nx = FIRST;
    endcase
    if (clear) state_nx = FIRST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      cnt_q     <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      case (state)
        FIRST: begin
          if (in_valid) begin
            max_q     <= in_data;
            min_q     <= in_data;
            max_idx_q <= '0;
            min_idx_q <= '0;
            cnt_q     <= (IDXW + 1)'(1);
          end
        end
        NEXT: begin
          if (in_valid) sample_q <= in_data;
        end
        CMP_MAX: begin
          if (cmp_gt) begin
            max_q     <= sample_q;
            max_idx_q <= cnt_q[IDXW-1:0];
          end
        end
        CMP_MIN: begin
          if (cmp_lt) begin
            min_q     <= sample_q;
            min_idx_q <= cnt_q[IDXW-1:0];
          end
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
module tb_minmax_scan_ctrl;

  typedef logic [3:0] frame_t [16];

  typedef struct {
    frame_t s;
    int     mx;
    int     mxi;
    int     mn;
    int     mni;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic       v8 = 1'b0, v2 = 1'b0, v16 = 1'b0;

  logic       r8, ov8;
  logic [3:0] mx8, mn8;
  logic [2:0] mxi8, mni8;
  logic       r2, ov2;
  logic [3:0] mx2, mn2;
  logic [0:0] mxi2, mni2;
  logic       r16, ov16;
  logic [3:0] mx16, mn16;
  logic [3:0] mxi16, mni16;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  minmax_scan_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v8), .in_data(in_data),
    .in_ready(r8), .out_valid(ov8), .out_ready(out_ready), .out_max(mx8),
    .out_min(mn8), .out_max_idx(mxi8), .out_min_idx(mni8)
  );

  minmax_scan_ctrl #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v2), .in_data(in_data),
    .in_ready(r2), .out_valid(ov2), .out_ready(out_ready), .out_max(mx2),
    .out_min(mn2), .out_max_idx(mxi2), .out_min_idx(mni2)
  );

  minmax_scan_ctrl #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v16), .in_data(in_data),
    .in_ready(r16), .out_valid(ov16), .out_ready(out_ready), .out_max(mx16),
    .out_min(mn16), .out_max_idx(mxi16), .out_min_idx(mni16)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return r8;
      1:       return r2;
      default: return r16;
    endcase
  endfunction

  task automatic set_v(input int sel, input logic v);
    case (sel)
      0:       v8 = v;
      1:       v2 = v;
      default: v16 = v;
    endcase
  endtask

  task automatic get_out(input int sel, output logic ov, output int mx, output int mxi,
                         output int mn, output int mni);
    case (sel)
      0:       begin ov = ov8;  mx = mx8;  mxi = int'(mxi8);  mn = mn8;  mni = int'(mni8);  end
      1:       begin ov = ov2;  mx = mx2;  mxi = int'(mxi2);  mn = mn2;  mni = int'(mni2);  end
      default: begin ov = ov16; mx = mx16; mxi = int'(mxi16); mn = mn16; mni = int'(mni16); end
    endcase
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input int sel, input logic [3:0] d, input int gap_pct);
    int g;
    g = 0;
    while (gap_pct > 0 && g < 8 && int'($urandom_range(0, 99)) < gap_pct) begin
      set_v(sel, 1'b0);
      @(negedge clk);
      g++;
    end
    in_data = d;
    set_v(sel, 1'b1);
    g = 0;
    while (!rdy(sel)) begin
      @(negedge clk);
      g++;
      if (g > 60) begin
        chk("push_ready_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    set_v(sel, 1'b0);
  endtask

  task automatic run_frame(input int sel, input frame_t s, input int len, input int gap_pct,
                           output int e0);
    e0 = 0;
    for (int i = 0; i < len; i++) begin
      push(sel, s[i], gap_pct);
      if (i == 0) e0 = cyc;
    end
  endtask

  task automatic expect_result(input int sel, input string nm, input int mx, input int mxi,
                               input int mn, input int mni, input int hold, output int seen);
    logic ov;
    int a, b, c, d, g;
    int snap;
    g = 0;
    get_out(sel, ov, a, b, c, d);
    while (!ov && g < 120) begin
      @(negedge clk);
      g++;
      get_out(sel, ov, a, b, c, d);
    end
    seen = cyc;
    chk({nm, "_valid"}, int'(ov), 1);
    chk({nm, "_max"}, a, mx);
    chk({nm, "_max_idx"}, b, mxi);
    chk({nm, "_min"}, c, mn);
    chk({nm, "_min_idx"}, d, mni);
    snap = (a << 12) | (b << 8) | (c << 4) | d;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      get_out(sel, ov, a, b, c, d);
      chk({nm, "_hold_valid"}, int'(ov), 1);
      chk({nm, "_hold_in_ready"}, int'(rdy(sel)), 0);
      chk({nm, "_hold_stable"}, (a << 12) | (b << 8) | (c << 4) | d, snap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    get_out(sel, ov, a, b, c, d);
    chk({nm, "_post_valid"}, int'(ov), 0);
    chk({nm, "_post_in_ready"}, int'(rdy(sel)), 1);
  endtask

  // Reference: extremes first, then the earliest position holding each.
  function automatic void model(input frame_t s, input int len, output int mx, output int mxi,
                                output int mn, output int mni);
    int vals[$];
    int hits[$];
    for (int i = 0; i < len; i++) vals.push_back(int'(s[i]));
    hits = vals.max();
    mx   = hits[0];
    hits = vals.min();
    mn   = hits[0];
    hits = vals.find_first_index(x) with (x == mx);
    mxi  = hits[0];
    hits = vals.find_first_index(x) with (x == mn);
    mni  = hits[0];
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    vec_t   tbl[4];
    frame_t f;
    int     e0, seen;
    int     mx, mxi, mn, mni;
    logic   ov;
    int     a, b, c, d;

    tbl[0].s = '{3, 9, 1, 9, 0, 15, 4, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].mx = 15; tbl[0].mxi = 5; tbl[0].mn = 0; tbl[0].mni = 4;
    tbl[1].s = '{5, 5, 5, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].mx = 5;  tbl[1].mxi = 0; tbl[1].mn = 5; tbl[1].mni = 0;
    tbl[2].s = '{9, 2, 9, 2, 9, 2, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].mx = 9;  tbl[2].mxi = 0; tbl[2].mn = 2; tbl[2].mni = 1;
    tbl[3].s = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].mx = 8;  tbl[3].mxi = 7; tbl[3].mn = 1; tbl[3].mni = 0;

    // Power-up reset
    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(r8), 1);
    get_out(0, ov, a, b, c, d);
    chk("reset_out_valid", int'(ov), 0);
    chk("reset_outputs", (a << 12) | (b << 8) | (c << 4) | d, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, gap-free; DONE must be entered in cycle 3N-2
    for (int t = 0; t < 4; t++) begin
      run_frame(0, tbl[t].s, 8, 0, e0);
      expect_result(0, $sformatf("tbl%0d", t), tbl[t].mx, tbl[t].mxi, tbl[t].mn, tbl[t].mni,
                    0, seen);
      chk($sformatf("tbl%0d_done_cycle", t), seen - e0 + 1, 22);
    end

    // Random frames, gap-free and with source gaps, against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) f[i] = 4'($urandom_range(0, 15));
      if (r == 3) for (int i = 0; i < 16; i++) f[i] = 4'($urandom_range(6, 7));
      model(f, 8, mx, mxi, mn, mni);
      run_frame(0, f, 8, 0, e0);
      expect_result(0, "rand_nogap", mx, mxi, mn, mni, 0, seen);
      run_frame(0, f, 8, 40, e0);
      expect_result(0, "rand_gap", mx, mxi, mn, mni, 0, seen);
    end

    // Reset while in CMP_MAX
    push(0, 4'd7, 0);
    push(0, 4'd3, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_in_ready", int'(r8), 1);
    get_out(0, ov, a, b, c, d);
    chk("midreset_out_valid", int'(ov), 0);
    chk("midreset_outputs", (a << 12) | (b << 8) | (c << 4) | d, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, tbl[0].s, 8, 0, e0);
    expect_result(0, "after_reset", 15, 5, 0, 4, 0, seen);
    chk("after_reset_done_cycle", seen - e0 + 1, 22);

    // Backpressure in DONE for 10 cycles
    run_frame(0, tbl[2].s, 8, 0, e0);
    expect_result(0, "backpressure", 9, 0, 2, 1, 10, seen);

    // Clear after 4 samples, then 1..8
    push(0, 4'd15, 0);
    push(0, 4'd0, 0);
    push(0, 4'd15, 0);
    push(0, 4'd0, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_in_ready", int'(r8), 1);
    chk("clear_out_valid", int'(ov8), 0);
    run_frame(0, tbl[3].s, 8, 0, e0);
    expect_result(0, "after_clear", 8, 7, 1, 0, 0, seen);

    // Clear coincident with an accept in NEXT drops that sample
    push(0, 4'd5, 0);
    push(0, 4'd5, 0);
    push(0, 4'd5, 0);
    for (int g = 0; g < 10 && !r8; g++) @(negedge clk);
    in_data = 4'd0;
    v8 = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    v8 = 1'b0;
    chk("clear_accept_in_ready", int'(r8), 1);
    for (int i = 0; i < 16; i++) f[i] = 4'(i + 6);
    run_frame(0, f, 8, 0, e0);
    expect_result(0, "clear_accept", 13, 7, 6, 0, 0, seen);

    // N=2 build
    f = '{4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, f, 2, 0, e0);
    expect_result(1, "n2", 4, 0, 3, 1, 0, seen);
    chk("n2_done_cycle", seen - e0 + 1, 4);
    for (int i = 0; i < 16; i++) f[i] = 4'($urandom_range(0, 15));
    model(f, 2, mx, mxi, mn, mni);
    run_frame(1, f, 2, 30, e0);
    expect_result(1, "n2_rand", mx, mxi, mn, mni, 0, seen);

    // N=16 build
    for (int i = 0; i < 16; i++) f[i] = 4'(i);
    run_frame(2, f, 16, 0, e0);
    expect_result(2, "n16_asc", 15, 15, 0, 0, 0, seen);
    chk("n16_done_cycle", seen - e0 + 1, 46);
    for (int i = 0; i < 16; i++) f[i] = 4'(15 - i);
    run_frame(2, f, 16, 0, e0);
    expect_result(2, "n16_desc", 15, 0, 0, 15, 0, seen);
    for (int i = 0; i < 16; i++) f[i] = 4'($urandom_range(0, 15));
    model(f, 16, mx, mxi, mn, mni);
    run_frame(2, f, 16, 30, e0);
    expect_result(2, "n16_rand", mx, mxi, mn, mni, 0, seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
